generic_sram_arbiter: RTL



---
 rtl/generic_sram_arbiter_if.sv | 20 ++
 rtl/generic_sram_arbiter.sv | 90 +++++++++
 2 files changed

// File: rtl/generic_sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: per-master req/we/be/addr/wdata in,
// one-hot gnt/rvalid and a shared rdata out.
interface generic_sram_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_SIZE   = 10,
  parameter int WORD_SIZE   = 32,
  parameter int BE_WIDTH    = 4
);
  logic [NUM_MASTERS-1:0]           req;
  logic [NUM_MASTERS-1:0]           we;
  logic [NUM_MASTERS*BE_WIDTH-1:0]  be;
  logic [NUM_MASTERS*ADDR_SIZE-1:0] addr;
  logic [NUM_MASTERS*WORD_SIZE-1:0] wdata;
  logic [NUM_MASTERS-1:0]           gnt;
  logic [NUM_MASTERS-1:0]           rvalid;
  logic [WORD_SIZE-1:0]             rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/generic_sram_arbiter.sv
// Round-robin arbiter sharing one single-port active-low SRAM between
// NUM_MASTERS requesters; routes each registered response back to its issuer.
module generic_sram_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_SIZE   = 10,
  parameter int WORD_SIZE   = 32,
  parameter int BE_WIDTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  generic_sram_arbiter_if.slave bus,
  output logic [ADDR_SIZE-1:0] sram_addr,
  output logic                 sram_ce_n,
  output logic                 sram_we_n,
  output logic [BE_WIDTH-1:0]  sram_be_n,
  output logic [WORD_SIZE-1:0] sram_wdata,
  input  logic [WORD_SIZE-1:0] sram_rdata
);
  localparam int PTR_W = $clog2(NUM_MASTERS);

  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_rsp_id;
  logic             r_rsp_vld;
  logic             r_rsp_rd;

  logic [PTR_W-1:0] w_winner;
  logic [PTR_W:0]   w_idx;
  logic             w_found;
  logic             w_grant_vld;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
      if (w_idx >= (PTR_W+1)'(NUM_MASTERS)) w_idx = w_idx - (PTR_W+1)'(NUM_MASTERS);
      if (!w_found && bus.req[w_idx[PTR_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[PTR_W-1:0];
      end
    end
    // Grant is suppressed while reset is held so nothing reaches the SRAM.
    w_grant_vld = w_found && rst_n;
  end

  always_comb begin
    bus.gnt    = '0;
    sram_ce_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_be_n  = '1;
    sram_addr  = '0;
    sram_wdata = '0;
    if (w_grant_vld) begin
      bus.gnt[w_winner] = 1'b1;
      sram_ce_n  = 1'b0;
      sram_we_n  = ~bus.we[w_winner];
      sram_be_n  = ~bus.be[w_winner*BE_WIDTH +: BE_WIDTH];
      sram_addr  = bus.addr[w_winner*ADDR_SIZE +: ADDR_SIZE];
      sram_wdata = bus.wdata[w_winner*WORD_SIZE +: WORD_SIZE];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_id  <= '0;
      r_rsp_rd  <= 1'b0;
    end else begin
      if (w_grant_vld) begin
        r_rr_ptr <= (w_winner == PTR_W'(NUM_MASTERS-1)) ? '0 : w_winner + 1'b1;
      end
      r_rsp_vld <= w_grant_vld;
      r_rsp_id  <= w_winner;
      r_rsp_rd  <= ~bus.we[w_winner];
    end
  end

  // The SRAM only refreshes dataout on reads, so write responses return zero.
  always_comb begin
    bus.rvalid = '0;
    if (r_rsp_vld) bus.rvalid[r_rsp_id] = 1'b1;
    bus.rdata = (r_rsp_vld && r_rsp_rd) ? sram_rdata : '0;
  end
endmodule
